// File: rtl/reel_controller.sv
// Three-reel slot controller: reels animate from the live digit, stop in a staggered sequence,
// and the final combination is scored. Define REEL_CREDIT_EN to add a saturating credit counter.
module reel_controller #(
  parameter int SPIN_CYCLES    = 100,
  parameter int STAGGER_CYCLES = 50,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spin,
  input  logic [3:0] random_number,
  output logic [3:0] reel0,
  output logic [3:0] reel1,
  output logic [3:0] reel2,
  output logic       busy,
  output logic       result_valid,
  output logic       jackpot,
  output logic       pair
`ifdef REEL_CREDIT_EN
  ,
  output logic [7:0] credits
`endif
);

  typedef enum logic [2:0] {IDLE, SPIN, STOP1, STOP2, EVAL} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] timer;
  logic             spin_q;
  logic             spin_rise;
  logic             can_accept;
  logic             accept;
  logic             spin_done;
  logic             stagger_done;
  logic [3:0]       digit;
  logic             eval_jackpot;
  logic             eval_pair;

  assign spin_rise    = spin & ~spin_q;
  // The generator may glitch above 9; fold those codes back into 0-5.
  assign digit        = (random_number >= 4'd10) ? (random_number - 4'd10) : random_number;
  assign spin_done    = (timer == CNT_W'(SPIN_CYCLES - 1));
  assign stagger_done = (timer == CNT_W'(STAGGER_CYCLES - 1));
  assign eval_jackpot = (reel0 == reel1) && (reel1 == reel2);
  assign eval_pair    = !eval_jackpot &&
                        ((reel0 == reel1) || (reel1 == reel2) || (reel0 == reel2));

`ifdef REEL_CREDIT_EN
  logic [8:0] credit_sum;

  assign can_accept = (credits != 8'd0);
  assign credit_sum = {1'b0, credits} +
                      (eval_jackpot ? 9'd50 : (eval_pair ? 9'd5 : 9'd0));
`else
  assign can_accept = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (spin_rise && can_accept) begin
          accept     = 1'b1;
          state_next = SPIN;
        end
      end
      SPIN:    if (spin_done)    state_next = STOP1;
      STOP1:   if (stagger_done) state_next = STOP2;
      STOP2:   if (stagger_done) state_next = EVAL;
      EVAL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Each reel keeps loading the live digit until its stop cycle; the last load is its final value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spin_q       <= 1'b0;
      timer        <= '0;
      reel0        <= 4'd0;
      reel1        <= 4'd0;
      reel2        <= 4'd0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      jackpot      <= 1'b0;
      pair         <= 1'b0;
`ifdef REEL_CREDIT_EN
      credits      <= 8'd10;
`endif
    end else begin
      spin_q       <= spin;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            timer   <= '0;
            busy    <= 1'b1;
            jackpot <= 1'b0;
            pair    <= 1'b0;
`ifdef REEL_CREDIT_EN
            credits <= credits - 8'd1;
`endif
          end
        end
        SPIN: begin
          reel0 <= digit;
          reel1 <= digit;
          reel2 <= digit;
          timer <= spin_done ? '0 : timer + 1'b1;
        end
        STOP1: begin
          reel1 <= digit;
          reel2 <= digit;
          timer <= stagger_done ? '0 : timer + 1'b1;
        end
        STOP2: begin
          reel2 <= digit;
          timer <= stagger_done ? '0 : timer + 1'b1;
        end
        EVAL: begin
          jackpot      <= eval_jackpot;
          pair         <= eval_pair;
          result_valid <= 1'b1;
          busy         <= 1'b0;
`ifdef REEL_CREDIT_EN
          credits      <= credit_sum[8] ? 8'd255 : credit_sum[7:0];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reel_controller.sv
// Scoreboard bench for reel_controller with SPIN_CYCLES=4, STAGGER_CYCLES=2 (9-cycle result latency).
// Credit checks compile in when REEL_CREDIT_EN is defined.
module tb_reel_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spin = 1'b0;
  logic [3:0] random_number = 4'd0;
  logic [3:0] reel0, reel1, reel2;
  logic       busy, result_valid, jackpot, pair;
`ifdef REEL_CREDIT_EN
  logic [7:0] credits;
  int         exp_cred = 10;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic last_jp = 1'b0;
  logic last_pr = 1'b0;

  typedef struct {
    logic [3:0] r0, r1, r2;
    logic       jp, pr;
    int         due;
  } exp_t;

  exp_t sbq[$];

  reel_controller #(.SPIN_CYCLES(4), .STAGGER_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .spin(spin),
    .random_number(random_number),
    .reel0(reel0),
    .reel1(reel1),
    .reel2(reel2),
    .busy(busy),
    .result_valid(result_valid),
    .jackpot(jackpot),
    .pair(pair)
`ifdef REEL_CREDIT_EN
    ,
    .credits(credits)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] san(input logic [3:0] d);
    return (d >= 4'd10) ? d - 4'd10 : d;
  endfunction

  // Result monitor: every result_valid pulse must match the oldest outstanding spin.
  always @(negedge clk) begin
    if (!rst && result_valid) begin
      if (sbq.size() == 0) begin
        checkOutput("spurious_result_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checkOutput("latency_cycle", cyc, e.due);
        checkOutput("reel0", reel0, e.r0);
        checkOutput("reel1", reel1, e.r1);
        checkOutput("reel2", reel2, e.r2);
        checkOutput("jackpot", jackpot, e.jp);
        checkOutput("pair", pair, e.pr);
        checkOutput("busy_after_eval", busy, 0);
      end
    end
  end

  // Drives one accepted spin over 10 cycles; digits s0/s1/s2 land on the three stop edges,
  // fill everywhere else. spin_pat[k] is the spin level before edge k. abort_k>=0 resets there.
  task automatic applyStimulus(input logic [3:0] s0, s1, s2, fill,
                               input logic [9:0] spin_pat, input int abort_k);
    exp_t e;
    spin = 1'b0;
    @(negedge clk);
    checkOutput("jackpot_hold", jackpot, last_jp);
    checkOutput("pair_hold", pair, last_pr);
    if (abort_k < 0) begin
      e.r0 = san(s0);
      e.r1 = san(s1);
      e.r2 = san(s2);
      e.jp = (e.r0 == e.r1) && (e.r1 == e.r2);
      e.pr = !e.jp && ((e.r0 == e.r1) || (e.r1 == e.r2) || (e.r0 == e.r2));
      e.due = cyc + 10;
      sbq.push_back(e);
    end
`ifdef REEL_CREDIT_EN
    exp_cred = exp_cred - 1;
`endif
    for (int k = 0; k < 10; k++) begin
      if (k == 1) checkOutput("busy_rise", busy, 1);
      if (k == abort_k) begin
        rst = 1'b1;
        #1;
        checkOutput("abort_reel0", reel0, 0);
        checkOutput("abort_reel1", reel1, 0);
        checkOutput("abort_reel2", reel2, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_flags", {result_valid, jackpot, pair}, 0);
`ifdef REEL_CREDIT_EN
        exp_cred = 10;
        checkOutput("abort_credits", credits, exp_cred);
`endif
        spin = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_jp = 1'b0;
        last_pr = 1'b0;
        return;
      end
      random_number = (k == 4) ? s0 : (k == 6) ? s1 : (k == 8) ? s2 : fill;
      spin = spin_pat[k];
      @(negedge clk);
    end
    last_jp = e.jp;
    last_pr = e.pr;
`ifdef REEL_CREDIT_EN
    exp_cred = exp_cred + (e.jp ? 50 : (e.pr ? 5 : 0));
    if (exp_cred > 255) exp_cred = 255;
    checkOutput("credits", credits, exp_cred);
`endif
  endtask

  initial begin
    #12;
    checkOutput("reset_reels", {reel0, reel1, reel2}, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_flags", {result_valid, jackpot, pair}, 0);
`ifdef REEL_CREDIT_EN
    checkOutput("reset_credits", credits, 10);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(4'd7, 4'd7, 4'd7, 4'd7, 10'b0000000001, -1);
    applyStimulus(4'd3, 4'd3, 4'd5, 4'd8, 10'b0000000001, -1);
    applyStimulus(4'd1, 4'd2, 4'd4, 4'd6, 10'b0000000001, -1);
    applyStimulus(4'd12, 4'd12, 4'd12, 4'd12, 10'b0000000001, -1);
    applyStimulus(4'd13, 4'd0, 4'd11, 4'd9, 10'b0000000001, -1);

    // Mid-SPIN pulse and a rise coinciding with EVAL must both be dropped.
    applyStimulus(4'd5, 4'd6, 4'd5, 4'd0, 10'b1000000101, -1);
    spin = 1'b0;
    repeat (14) @(negedge clk);

    // Spin held high for 20 cycles yields exactly one result.
    applyStimulus(4'd4, 4'd4, 4'd4, 4'd1, 10'h3FF, -1);
    repeat (10) @(negedge clk);
    spin = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("held_spin_idle", busy, 0);

    // Reset while in STOP1, then a clean spin.
    applyStimulus(4'd9, 4'd9, 4'd9, 4'd2, 10'b0000000001, 6);
    repeat (3) @(negedge clk);
    checkOutput("post_abort_idle", {busy, result_valid}, 0);
    applyStimulus(4'd2, 4'd9, 4'd2, 4'd3, 10'b0000000001, -1);

`ifdef REEL_CREDIT_EN
    // Jackpots push credits up until they clip at 255.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cred = 10;
    last_jp = 1'b0;
    last_pr = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(4'd8, 4'd8, 4'd8, 4'd8, 10'b0000000001, -1);
    checkOutput("credits_saturated", credits, 255);

    // Ten scoreless spins drain a fresh balance; the eleventh is refused.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cred = 10;
    last_jp = 1'b0;
    last_pr = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus(4'd1, 4'd2, 4'd4, 4'd0, 10'b0000000001, -1);
    checkOutput("credits_drained", credits, 0);
    @(negedge clk);
    spin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("no_credit_busy", busy, 0);
    end
    spin = 1'b0;
    checkOutput("no_credit_credits", credits, 0);
`endif

    repeat (12) @(negedge clk);
    if (sbq.size() != 0) checkOutput("missing_results", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
